sel_capture_fifo: RTL and testbench

Captures 8-bit data words on every clock edge where `sel` is high and buffers them in a small first-word-fall-through FIFO. A downstream consumer drains them through a valid/ready handshake. The block sits directly downstream of the `sel`/`d` mux stage and turns its qualified samples into a registered, flow-controlled stream. Words that arrive while the FIFO is full are dropped, and the drop is flagged by a sticky overflow bit.

---
 rtl/sel_capture_pkg.sv | 12 +
 rtl/sel_capture_mem.sv | 26 ++
 rtl/sel_capture_fifo.sv | 94 +++++++++
 tb/tb_sel_capture_fifo.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/sel_capture_pkg.sv
// rtl/sel_capture_pkg.sv - shared constants and types for the sel capture FIFO
package sel_capture_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    localparam int DEF_PTR_W = $clog2(DEF_DEPTH);
    localparam int DEF_CNT_W = $clog2(DEF_DEPTH) + 1;

    typedef logic [DEF_WIDTH-1:0] data_t;

endpackage

// File: rtl/sel_capture_mem.sv
// rtl/sel_capture_mem.sv - DEPTH x WIDTH register array, one write port, async read port
module sel_capture_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents need no reset: the occupancy count decides what is valid.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sel_capture_fifo.sv
// rtl/sel_capture_fifo.sv - captures d on sel into a first-word-fall-through FIFO with sticky overflow
module sel_capture_fifo
    import sel_capture_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       sel,
    input  logic [WIDTH-1:0]           d,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       overflow,
    input  logic                       clr_ovf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;
    logic [WIDTH-1:0] head;

    logic push;
    logic pop;
    logic accept;
    logic drop;

    assign out_valid = (cnt_q != '0);
    assign full      = (cnt_q == CNT_FULL);
    assign count     = cnt_q;
    assign overflow  = ovf_q;

    assign push   = sel;
    assign pop    = out_valid && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;

    sel_capture_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (accept),
        .waddr (wr_ptr),
        .wdata (d),
        .raddr (rd_ptr),
        .rdata (head)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap.
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({accept, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    always_comb begin
        out_data = '0;
        if (out_valid) begin
            out_data = head;
        end
    end

endmodule

// File: tb/tb_sel_capture_fifo.sv
// tb/tb_sel_capture_fifo.sv - directed and random checks of sel_capture_fifo against a queue model
module tb_sel_capture_fifo;
    import sel_capture_pkg::*;

    localparam int DEPTH = DEF_DEPTH;

    logic                 clk;
    logic                 rstn;
    logic                 sel;
    data_t                d;
    logic                 out_valid;
    logic                 out_ready;
    data_t                out_data;
    logic [DEF_CNT_W-1:0] count;
    logic                 full;
    logic                 overflow;
    logic                 clr_ovf;

    int    total;
    int    bad;
    data_t q[$];
    logic  m_ovf;

    sel_capture_fifo #(
        .WIDTH (DEF_WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .sel       (sel),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .full      (full),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count"},    32'(count),     32'(q.size()));
        check({tag, ".valid"},    32'(out_valid), 32'(q.size() != 0));
        check({tag, ".full"},     32'(full),      32'(q.size() == DEPTH));
        check({tag, ".data"},     32'(out_data),  (q.size() != 0) ? 32'(q[0]) : 32'd0);
        check({tag, ".overflow"}, 32'(overflow),  32'(m_ovf));
    endtask

    // One clock: apply inputs, advance the model by the FIFO rules, compare after the edge.
    task automatic step(input string tag, input logic s, input data_t dv, input logic rdy, input logic clr);
        bit was_full;
        bit did_pop;
        sel       = s;
        d         = dv;
        out_ready = rdy;
        clr_ovf   = clr;
        @(posedge clk);
        was_full = (q.size() == DEPTH);
        did_pop  = (q.size() != 0) && rdy;
        if (did_pop) void'(q.pop_front());
        if (s && (!was_full || did_pop)) q.push_back(dv);
        if (s && was_full && !did_pop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        #1;
        check_all(tag);
    endtask

    task automatic fill_1_to_4();
        for (int i = 1; i <= 4; i++) step("fill", 1'b1, data_t'(i), 1'b0, 1'b0);
    endtask

    task automatic drain(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        m_ovf     = 1'b0;
        rstn      = 1'b0;
        sel       = 1'b0;
        d         = '0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;

        // Reset then idle
        #1 check_all("reset0");
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1 check_all("reset_hold");
        end
        #2 rstn = 1'b1;
        for (int i = 0; i < 3; i++) step("idle", 1'b0, 8'h5a, 1'b1, 1'b0);

        // Fill and drain
        fill_1_to_4();
        drain("drain", 5);

        // Overflow: 5 is dropped, head stays 1
        fill_1_to_4();
        step("ovf_push", 1'b1, 8'd5, 1'b0, 1'b0);
        check("ovf_set", 32'(overflow), 32'd1);
        drain("ovf_drain", 5);
        step("ovf_clr", 1'b0, '0, 1'b0, 1'b1);
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Full with simultaneous push and pop
        fill_1_to_4();
        step("full_pp", 1'b1, 8'd9, 1'b1, 1'b0);
        check("full_pp_head", 32'(out_data), 32'd2);
        drain("full_pp_drain", 5);

        // Streaming wrap-around, count holds at 1
        for (int i = 0; i < 10; i++) begin
            step("stream", 1'b1, data_t'(i), 1'b1, 1'b0);
            check("stream_count", 32'(count), 32'd1);
        end
        drain("stream_drain", 2);

        // Reset mid-stream
        for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, data_t'(8'h30 + i), 1'b0, 1'b0);
        #2 rstn = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        #1 check_all("mid_rst");
        @(posedge clk);
        #2 rstn = 1'b1;
        step("post_rst", 1'b1, 8'haa, 1'b0, 1'b0);
        check("post_rst_head", 32'(out_data), 32'haa);
        drain("post_rst_drain", 2);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step("rand",
                 ($urandom_range(0, 99) < 60),
                 data_t'($urandom),
                 ($urandom_range(0, 99) < 45),
                 ($urandom_range(0, 99) < 5));
        end
        drain("final_drain", DEPTH + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
